// File: rtl/h_adder_pkg.sv
// Shared definitions for the chunked adder: FSM state encoding and the
// chunk-count / chunk-index-width helpers.
package h_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk steps for a given word width and chunk size.
  function automatic int chunk_count(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  // Width of the chunk index register; at least one bit even when N = 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/h_ripple_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice. Also exposes the carry
// into its MSB so the caller can form the signed overflow flag.
module h_ripple_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign sum_o[gi]      = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi + 1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry[CHUNK];
  assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/h_chunk_adder.sv
// Multi-cycle adder: adds CHUNK bits per cycle, LSB chunk first, with a
// registered inter-chunk carry. Define HADDER_SUB_EN to add the sub port.
module h_chunk_adder
  import h_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef HADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N    = chunk_count(WIDTH, CHUNK);
  localparam int IDXW = idx_width(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("h_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  chunk_sum;
  logic              chunk_cout;
  logic              chunk_cmsb;
  logic              accept;
  logic              last_chunk;
  logic [WIDTH-1:0]  b_capture;
  logic              cin_capture;

  assign accept     = start && (state_q == IDLE || state_q == DONE);
  assign last_chunk = (idx_q == LAST_IDX);

`ifdef HADDER_SUB_EN
  assign b_capture   = sub ? ~b : b;
  assign cin_capture = sub ? 1'b1 : carry_in;
`else
  assign b_capture   = b;
  assign cin_capture = carry_in;
`endif

  h_ripple_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i    (a_q[CHUNK-1:0]),
    .b_i    (b_q[CHUNK-1:0]),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout),
    .cmsb_o (chunk_cmsb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // a_q doubles as the result shift register: each step drops the consumed
  // operand chunk and inserts the new sum chunk at the top.
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      idx_d   = '0;
      a_d     = a;
      b_d     = b_capture;
      carry_d = cin_capture;
    end else if (state_q == RUN) begin
      idx_d   = idx_q + IDXW'(1);
      a_d     = WIDTH'({chunk_sum, a_q} >> CHUNK);
      b_d     = b_q >> CHUNK;
      carry_d = chunk_cout;
      if (last_chunk) begin
        out_d  = WIDTH'({chunk_sum, a_q} >> CHUNK);
        cout_d = chunk_cout;
        ovf_d  = chunk_cmsb ^ chunk_cout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out       = out_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_h_chunk_adder.sv
// Self-checking bench for h_chunk_adder (WIDTH=16, CHUNK=4): directed cases
// plus randomized operands against an arithmetic reference model.
module tb_h_chunk_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
`ifdef HADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, carry_in, sub;
  logic [15:0] a, b;
  logic        busy, done, carry_out, overflow;
  logic [15:0] out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  h_chunk_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef HADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .out       (out),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Reference: {overflow, carry_out, sum[15:0]} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic cv, input logic sv);
    logic [15:0] bb;
    logic        c;
    logic [31:0] s;
    logic        ov;
    if (SUB_EN && sv) begin
      bb = ~bv;
      c  = 1'b1;
    end else begin
      bb = bv;
      c  = cv;
    end
    s  = 32'(av) + 32'(bb) + 32'(c);
    ov = (av[15] == bb[15]) && (s[15] != av[15]);
    return {ov, s[16], s[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after start was accepted; returns cycle count
  // (1 = that negedge) at which done was seen, bounded to 20.
  task automatic wait_done(input logic [15:0] hold_val, output int cyc,
                           output int busy_n, output logic hold_bad);
    cyc      = 1;
    busy_n   = 0;
    hold_bad = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_n++;
      if (out !== hold_val) hold_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic idle(input int n, input string tag);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check({tag, " idle"}, 32'(bad), 32'd0);
  endtask

  // Starts an operation at the current negedge and checks it to completion.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input logic sv, input string tag);
    logic [17:0] e;
    logic [15:0] hold;
    int          cyc, bn;
    logic        hb;
    e     = model(av, bv, cv, sv);
    hold  = out;
    start = 1'b1; a = av; b = bv; carry_in = cv; sub = sv;
    @(negedge clk);
    start    = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    carry_in = 1'($urandom);
    sub      = 1'($urandom);
    wait_done(hold, cyc, bn, hb);
    check({tag, " latency"}, 32'(cyc), 32'(N + 1));
    check({tag, " busy_cycles"}, 32'(bn), 32'(N));
    check({tag, " hold"}, 32'(hb), 32'd0);
    check({tag, " out"}, 32'(out), 32'(e[15:0]));
    check({tag, " carry_out"}, 32'(carry_out), 32'(e[16]));
    check({tag, " overflow"}, 32'(overflow), 32'(e[17]));
    $display("[TB] %s a=%h b=%h cin=%0d sub=%0d -> out=%h cout=%0d ovf=%0d lat=%0d",
             tag, av, bv, cv, sv, out, carry_out, overflow, cyc);
  endtask

  initial begin
    logic [17:0] e;
    logic [15:0] hold;
    int          cyc, bn;
    logic        hb;

    // Reset with start held high: reset must win.
    reset = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; carry_in = 1'b1; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", 32'(out), 32'd0);
    check("reset carry_out", 32'(carry_out), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "carry_chain");
    idle(2, "after carry_chain");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
    idle(1, "after wrap");
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin_only");
    idle(1, "after cin_only");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "signed_ovf");
    // Back-to-back: start issued at the done negedge of the previous op.
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, "back_to_back");
    idle(1, "after back_to_back");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pre_abort");
    idle(1, "after pre_abort");

    // Reset asserted in the third RUN cycle aborts the operation.
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort out", 32'(out), 32'd0);
    check("abort carry_out", 32'(carry_out), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    idle(8, "after abort");
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "post_abort");
    idle(1, "after post_abort");

    // Start pulsed again in RUN cycle 2 with new operands must be ignored.
    e     = model(16'h0F0F, 16'h1111, 1'b0, 1'b0);
    hold  = out;
    start = 1'b1; a = 16'h0F0F; b = 16'h1111; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(hold, cyc, bn, hb);
    check("run_start latency", 32'(cyc + 2), 32'(N + 1));
    check("run_start hold", 32'(hb), 32'd0);
    check("run_start out", 32'(out), 32'(e[15:0]));
    check("run_start carry_out", 32'(carry_out), 32'(e[16]));
    $display("[TB] run_start out=%h cout=%0d ovf=%0d", out, carry_out, overflow);
    idle(1, "after run_start");

    for (int i = 0; i < 24; i++) begin
      int gap;
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap, $sformatf("rand%0d", i));
    end

`ifdef HADDER_SUB_EN
    idle(1, "before sub");
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_neg");
    idle(1, "after sub_neg");
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, "sub_ovf");
`endif

    idle(2, "final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
